// File: rtl/collide_pipe.sv
// collide_pipe: fixed-latency D2Q9 BGK collision pipeline.
// One cell per cycle in, post-collision distributions out 4 edges later.
// A sweep-done pulse marks every NUM_CELLS-th valid output.
module collide_pipe #(
  parameter int NUM_CELLS   = 31570,
  parameter int OMEGA_SHIFT = 1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [8:0][7:0] data_in,
  input  logic            data_valid_in,
  output logic [8:0][7:0] data_out,
  output logic            data_valid_out,
  output logic            done_colliding_out
);

  localparam int            CW        = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam logic [CW-1:0] LAST_CELL = CW'(NUM_CELLS - 1);

  // t_i = rho + 3*(ex_i*mx + ey_i*my); directions 0..8 = C,N,NE,E,SE,S,SW,W,NW
  function automatic logic signed [13:0] t_of(input logic [3:0] dir,
                                              input logic [11:0] rho,
                                              input logic signed [10:0] mx,
                                              input logic signed [10:0] my);
    logic signed [11:0] x;
    logic signed [11:0] y;
    logic signed [11:0] em;
    x = {mx[10], mx};
    y = {my[10], my};
    case (dir)
      4'd0:    em = 12'sd0;
      4'd1:    em = y;
      4'd2:    em = x + y;
      4'd3:    em = x;
      4'd4:    em = x - y;
      4'd5:    em = -y;
      4'd6:    em = -x - y;
      4'd7:    em = -x;
      4'd8:    em = y - x;
      default: em = 12'sd0;
    endcase
    t_of = $signed({2'b00, rho}) + (14'sd3 * $signed({{2{em[11]}}, em}));
  endfunction

  // feq_i = floor(W_i * t_i * 1821 / 65536), weights 16 / 4 (axis) / 1 (diagonal)
  function automatic logic signed [15:0] feq_of(input logic [3:0] dir,
                                                input logic signed [13:0] t);
    logic signed [17:0] p;
    logic signed [31:0] prod;
    p = {{4{t[13]}}, t};
    case (dir)
      4'd0:                    p = p <<< 4;
      4'd1, 4'd3, 4'd5, 4'd7:  p = p <<< 2;
      4'd2, 4'd4, 4'd6, 4'd8:  p = p;
      default:                 p = p;
    endcase
    prod   = {{14{p[17]}}, p} * 32'sd1821;
    feq_of = 16'(prod >>> 16);
  endfunction

  // Relax f toward feq by 2^-OMEGA_SHIFT and clamp to the 8-bit range
  function automatic logic [7:0] out_of(input logic [7:0] f,
                                        input logic signed [15:0] feq);
    logic signed [16:0] d;
    logic signed [16:0] o;
    d = $signed({feq[15], feq}) - $signed({9'd0, f});
    o = $signed({9'd0, f}) + (d >>> OMEGA_SHIFT);
    if (o < 17'sd0) begin
      out_of = 8'd0;
    end else if (o > 17'sd255) begin
      out_of = 8'd255;
    end else begin
      out_of = o[7:0];
    end
  endfunction

  logic [8:0][7:0]    f0_q, f1_q, f2_q, f3_q;
  logic               v0_q, v1_q, v2_q, v3_q;
  logic [11:0]        rho1_q, rho1_d;
  logic signed [10:0] mx1_q, mx1_d, my1_q, my1_d;
  logic signed [13:0] t2_q [0:8];
  logic signed [13:0] t2_d [0:8];
  logic signed [15:0] feq3_q [0:8];
  logic signed [15:0] feq3_d [0:8];
  logic [8:0][7:0]    out_q, out_d;
  logic               vout_q, done_q, done_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [9:0]         xpos_s, xneg_s, ypos_s, yneg_s;

  // Stage 1 moments: density and momentum from the registered input cell
  always_comb begin
    rho1_d = 12'd0;
    for (int i = 0; i < 9; i++) begin
      rho1_d = rho1_d + {4'd0, f0_q[i]};
    end
    xpos_s = {2'd0, f0_q[2]} + {2'd0, f0_q[3]} + {2'd0, f0_q[4]};
    xneg_s = {2'd0, f0_q[6]} + {2'd0, f0_q[7]} + {2'd0, f0_q[8]};
    ypos_s = {2'd0, f0_q[1]} + {2'd0, f0_q[2]} + {2'd0, f0_q[8]};
    yneg_s = {2'd0, f0_q[4]} + {2'd0, f0_q[5]} + {2'd0, f0_q[6]};
    mx1_d  = $signed({1'b0, xpos_s}) - $signed({1'b0, xneg_s});
    my1_d  = $signed({1'b0, ypos_s}) - $signed({1'b0, yneg_s});
  end

  // Stages 2-4 datapath: per-direction t, feq and relaxed output
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      t2_d[i]   = t_of(4'(i), rho1_q, mx1_q, my1_q);
      feq3_d[i] = feq_of(4'(i), t2_q[i]);
      out_d[i]  = out_of(f3_q[i], feq3_q[i]);
    end
  end

  // Sweep counter: done accompanies the NUM_CELLS-th valid output, then wraps
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (v3_q) begin
      if (cnt_q == LAST_CELL) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CW'(1);
        done_d = 1'b0;
      end
    end else begin
      cnt_d  = cnt_q;
      done_d = 1'b0;
    end
  end

  // Pipeline registers; reset drops every in-flight cell and the partial count
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      f0_q   <= '0;
      f1_q   <= '0;
      f2_q   <= '0;
      f3_q   <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      rho1_q <= 12'd0;
      mx1_q  <= 11'sd0;
      my1_q  <= 11'sd0;
      for (int i = 0; i < 9; i++) begin
        t2_q[i]   <= 14'sd0;
        feq3_q[i] <= 16'sd0;
      end
      out_q  <= '0;
      vout_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      f0_q   <= data_in;
      f1_q   <= f0_q;
      f2_q   <= f1_q;
      f3_q   <= f2_q;
      v0_q   <= data_valid_in;
      v1_q   <= v0_q;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      rho1_q <= rho1_d;
      mx1_q  <= mx1_d;
      my1_q  <= my1_d;
      for (int i = 0; i < 9; i++) begin
        t2_q[i]   <= t2_d[i];
        feq3_q[i] <= feq3_d[i];
      end
      out_q  <= out_d;
      vout_q <= v3_q;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_out           = out_q;
  assign data_valid_out     = vout_q;
  assign done_colliding_out = done_q;

endmodule

// File: tb/tb_collide_pipe.sv
// tb_collide_pipe: table vectors, hand sequences for sweep/reset corners,
// and a randomized stream checked cycle-by-cycle against a reference model.
module tb_collide_pipe;

  localparam int NC = 4;
  localparam int OS = 1;
  localparam int EX [0:8] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
  localparam int EY [0:8] = '{0, 1, 1, 0, -1, -1, -1, 0, 1};
  localparam int WT [0:8] = '{16, 4, 1, 4, 1, 4, 1, 4, 1};

  typedef struct {
    logic            v;
    logic [8:0][7:0] f;
  } cell_t;

  typedef struct {
    logic [8:0][7:0] f;
    logic [8:0][7:0] exp;
  } vec_t;

  logic            clk, rst, vin, vout, done;
  logic [8:0][7:0] din, dout;
  int              checks = 0;
  int              errors = 0;
  int              mcount;
  cell_t           pipe_q[$];
  int              vout_hist[$];
  int              done_hist[$];
  vec_t            tbl [0:3];

  collide_pipe #(.NUM_CELLS(NC), .OMEGA_SHIFT(OS)) dut (
    .clk_in(clk), .rst_in(rst), .data_in(din), .data_valid_in(vin),
    .data_out(dout), .data_valid_out(vout), .done_colliding_out(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference BGK collision in plain integer arithmetic
  function automatic logic [8:0][7:0] ref_collide(input logic [8:0][7:0] f);
    int rho, mx, my, t, feq, d, o, fi;
    logic [8:0][7:0] r;
    rho = 0; mx = 0; my = 0;
    for (int i = 0; i < 9; i++) begin
      fi = int'(f[i]);
      rho += fi; mx += EX[i] * fi; my += EY[i] * fi;
    end
    for (int i = 0; i < 9; i++) begin
      fi  = int'(f[i]);
      t   = rho + 3 * (EX[i] * mx + EY[i] * my);
      feq = (WT[i] * t * 1821) >>> 16;
      d   = feq - fi;
      o   = fi + (d >>> OS);
      if (o < 0) o = 0;
      else if (o > 255) o = 255;
      r[i] = 8'(o);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    cell_t b;
    b.v = 1'b0; b.f = '0;
    pipe_q = {};
    repeat (4) pipe_q.push_back(b);
    mcount = 0;
  endtask

  // Drive one cycle, then compare outputs with the model's 4-cycle-old cell
  task automatic cycle(input logic v, input logic [8:0][7:0] f);
    cell_t c, e;
    logic  exp_done;
    vin = v; din = f;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
      check("rst_valid", 72'(vout), 72'd0);
      check("rst_done", 72'(done), 72'd0);
      check("rst_data", dout, 72'd0);
    end else begin
      c.v = v; c.f = f;
      pipe_q.push_back(c);
      e = pipe_q.pop_front();
      exp_done = 1'b0;
      if (e.v) begin
        mcount++;
        if (mcount == NC) begin
          mcount = 0;
          exp_done = 1'b1;
        end
      end
      check("valid", 72'(vout), 72'(e.v));
      check("done", 72'(done), 72'(exp_done));
      if (e.v) check("data", dout, ref_collide(e.f));
    end
    vout_hist.push_back(int'(vout));
    done_hist.push_back(int'(done));
  endtask

  // Asynchronous reset between edges, held across one edge, released between edges
  task automatic do_reset(input bit chk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    if (chk) begin
      check("arst_valid", 72'(vout), 72'd0);
      check("arst_done", 72'(done), 72'd0);
      check("arst_data", dout, 72'd0);
    end
    cycle(1'b0, '0);
    rst = 1'b0;
  endtask

  initial begin
    int start, nv, nd, d1, d2, ord, sent, bad, idx4, didx;
    logic [8:0][7:0] f;
    logic            v;

    tbl[0].f   = '0;
    tbl[0].exp = '0;
    tbl[1].f   = {9{8'd36}};
    tbl[1].exp = {8'd22, 8'd36, 8'd22, 8'd36, 8'd22, 8'd36, 8'd22, 8'd36, 8'd90};
    tbl[2].f   = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0};
    tbl[2].exp = {8'd0, 8'd0, 8'd0, 8'd14, 8'd14, 8'd184, 8'd14, 8'd14, 8'd56};
    tbl[3].f   = {9{8'd255}};
    tbl[3].exp = {8'd159, 8'd255, 8'd159, 8'd255, 8'd159, 8'd255, 8'd159, 8'd255, 8'd255};

    rst = 1'b1; vin = 1'b0; din = '0;
    model_reset();
    #12;
    check("reset_valid", 72'(vout), 72'd0);
    check("reset_done", 72'(done), 72'd0);
    check("reset_data", dout, 72'd0);
    rst = 1'b0;

    // Table vectors: single cell, result exactly 4 edges later, for one cycle
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, tbl[k].f);
      for (int j = 0; j < 4; j++) cycle(1'b0, '0);
      check($sformatf("table%0d_data", k), dout, tbl[k].exp);
      check($sformatf("table%0d_valid", k), 72'(vout), 72'd1);
      cycle(1'b0, '0);
      check($sformatf("table%0d_single", k), 72'(vout), 72'd0);
    end

    // Ten cells with a bubble after cell 2: done on outputs 4 and 8 only
    do_reset(1'b0);
    start = vout_hist.size();
    for (int n = 0; n < 11; n++) begin
      for (int i = 0; i < 9; i++) f[i] = 8'($urandom_range(0, 255));
      cycle((n == 2) ? 1'b0 : 1'b1, f);
    end
    for (int n = 0; n < 6; n++) cycle(1'b0, '0);
    nv = 0; nd = 0; d1 = -1; d2 = -1; ord = 0;
    for (int i = start; i < vout_hist.size(); i++) begin
      if (vout_hist[i] != 0) begin
        ord++; nv++;
        if (done_hist[i] != 0) begin
          nd++;
          if (d1 < 0) d1 = ord; else d2 = ord;
        end
      end
    end
    check("seq_valid_count", 72'(nv), 72'd10);
    check("seq_done_count", 72'(nd), 72'd2);
    check("seq_done_first", 72'(d1), 72'd4);
    check("seq_done_second", 72'(d2), 72'd8);
    check("seq_bubble", 72'(vout_hist[start + 6]), 72'd0);
    check("seq_around_bubble", 72'(vout_hist[start + 5] + vout_hist[start + 7]), 72'd2);

    // Reset with count=2 and three cells in flight
    do_reset(1'b0);
    for (int n = 0; n < 5; n++) cycle(1'b1, {9{8'd36}});
    cycle(1'b0, '0);
    check("pre_rst_valid", 72'(vout), 72'd1);
    do_reset(1'b1);
    start = vout_hist.size();
    for (int n = 0; n < 8; n++) cycle(1'b0, '0);
    nv = 0;
    for (int i = start; i < vout_hist.size(); i++) nv += vout_hist[i];
    check("no_stale", 72'(nv), 72'd0);
    start = vout_hist.size();
    for (int n = 0; n < 4; n++) cycle(1'b1, tbl[n].f);
    for (int n = 0; n < 5; n++) cycle(1'b0, '0);
    nv = 0; nd = 0; idx4 = -1; didx = -2;
    for (int i = start; i < vout_hist.size(); i++) begin
      if (vout_hist[i] != 0) begin
        nv++;
        if (nv == 4) idx4 = i;
      end
      if (done_hist[i] != 0) begin
        nd++;
        didx = i;
      end
    end
    check("post_rst_done_count", 72'(nd), 72'd1);
    check("post_rst_done_on_4th", 72'(didx - idx4), 72'd0);

    // Randomized stream with bubbles
    sent = 0;
    while (sent < 1000) begin
      v = ($urandom_range(0, 3) != 32'd0);
      for (int i = 0; i < 9; i++) begin
        case ($urandom_range(0, 7))
          0:       f[i] = 8'd0;
          1:       f[i] = 8'd255;
          default: f[i] = 8'($urandom_range(0, 255));
        endcase
      end
      cycle(v, f);
      if (v) sent++;
    end
    for (int n = 0; n < 6; n++) cycle(1'b0, '0);

    bad = 0;
    for (int i = 0; i < vout_hist.size(); i++) begin
      if (done_hist[i] != 0 && vout_hist[i] == 0) bad++;
    end
    check("done_without_valid", 72'(bad), 72'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/collide_pipe.md
# collide_pipe

Fixed-latency, fully pipelined BGK collision engine for the D2Q9 lattice-Boltzmann solver. It sits behind the LBM sweep controller, which streams one lattice cell per cycle read from the lattice BRAM. The block returns post-collision distributions on the write side. After the last cell of a sweep it pulses a sweep-done flag, which the controller uses to advance to streaming.

## Interface
- NUM_CELLS, 31570: lattice cells per sweep; number of valid outputs per done pulse.
- OMEGA_SHIFT, 1: relaxation rate omega = 2^-OMEGA_SHIFT; legal range 0..4.
- clk_in  in  1  system clock; all state changes on the rising edge.
- rst_in  in  1  reset, asynchronous, active-high.
- data_in  in  9x8 (packed [8:0][7:0])  pre-collision f0..f8, unsigned.
- data_valid_in  in  1  data_in holds a real cell this cycle.
- data_out  out  9x8 (packed [8:0][7:0])  post-collision f0..f8, unsigned.
- data_valid_out  out  1  data_out holds a real cell this cycle.
- done_colliding_out  out  1  one-cycle pulse coincident with the NUM_CELLS-th valid output.
- Direction order: 0 center, 1 N, 2 NE, 3 E, 4 SE, 5 S, 6 SW, 7 W, 8 NW.
- Unit vectors (ex,ey): (0,0), (0,1), (1,1), (1,0), (1,-1), (0,-1), (-1,-1), (-1,0), (-1,1).

## Operation
- No backpressure. Every cycle with data_valid_in=1 is accepted. Bubbles (valid=0) propagate unchanged.
- Stage 1 (input register and moments):
  - rho = sum f_i, 12b unsigned.
  - mx = (f2+f3+f4)-(f6+f7+f8), 11b signed.
  - my = (f1+f2+f8)-(f4+f5+f6), 11b signed.
  - f_i is carried forward.
- Stage 2:
  - em_i = ex_i*mx + ey_i*my, 12b signed.
  - t_i = rho + 3*em_i, 14b signed.
- Stage 3:
  - p_i = W_i*t_i, with W = 16 (i=0), 4 (i=1,3,5,7), 1 (i=2,4,6,8); 18b signed.
  - feq_i = (p_i*1821) >>> 16, arithmetic shift (floor); 1821/65536 ≈ 1/36.
- Stage 4:
  - d_i = feq_i - f_i (signed).
  - o_i = f_i + (d_i >>> OMEGA_SHIFT), arithmetic shift.
  - data_out[i] = o_i saturated to [0,255].
- All intermediates are sized so no internal overflow occurs for any 8-bit input. Mass is only approximately conserved, due to truncation and saturation; this is accepted.
- Sweep counter:
  - 15b (clog2 NUM_CELLS) counter of valid outputs.
  - On a valid output with count == NUM_CELLS-1: done_colliding_out=1 that cycle, and the counter returns to 0.
  - Otherwise the counter increments on each valid output.
  - The counter wraps per sweep; consecutive sweeps need no re-arm.
- Reset asserted mid-sweep discards all in-flight cells and the partial count. No output or done pulse is produced for discarded cells.

## Timing
- Latency: fixed at 4 cycles. A cell sampled at edge N appears with data_valid_out=1 after edge N+4.
- Throughput: 1 cell per cycle, back-to-back, indefinitely.
- Pipeline valid bits shift every cycle regardless of data_valid_in.
- Data registers may load unconditionally; data_out content is don't-care while data_valid_out=0.
- Reset values (asynchronous, immediate on rst_in rise):
  - all stage valid bits 0;
  - data_out 0;
  - data_valid_out 0;
  - done_colliding_out 0;
  - counter 0.
- First output after reset release: no earlier than 4 edges after the first accepted cell.
- NUM_CELLS=1: done pulses on every valid output.
- done_colliding_out is never asserted when data_valid_out=0. It is registered, not combinational from inputs.

## Test plan
- All f_i=0, one valid cell:
  - 4 cycles later, data_out all 0 and data_valid_out=1 for exactly one cycle.
- All f_i=36, OMEGA_SHIFT=1 (rho=324, m=0):
  - out0=90;
  - out1,3,5,7=36;
  - out2,4,6,8=22.
- f3=255, others 0, OMEGA_SHIFT=1:
  - out3=184 (feq=113);
  - out7=0 (feq=-57, saturates low);
  - out0=0+(feq0-0)>>>1 with feq0=(16*255*1821)>>>16=113, so out0=56.
- NUM_CELLS=4, feed 10 back-to-back valid cells with one bubble inserted after cell 2:
  - 10 valid outputs with the bubble preserved in position;
  - done pulses with outputs 4 and 8 only.
- Assert rst_in asynchronously (between edges) while 3 cells are in flight and count=2:
  - all outputs drop to 0 immediately;
  - after release, no stale outputs appear;
  - the next NUM_CELLS=4 valid cells produce done on the 4th.
- Randomized 1000-cell stream with random bubbles against a reference model of the stated integer arithmetic:
  - bit-exact data_out match;
  - latency always 4.
